// File: rtl/ad_read_write_master_if.sv
// rtl/ad_read_write_master_if.sv - host request/response and multiplexed address/data bus signals
interface ad_read_write_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [31:0] ad_in;
  logic        ale;
  logic        read_n;
  logic        write_n;
  logic        ack;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, ad_in, ack,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, ad_out, ad_oe, ale, read_n, write_n
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, ad_in, ack,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, ad_out, ad_oe, ale, read_n, write_n
  );
endinterface

// File: rtl/ad_read_write_master.sv
// rtl/ad_read_write_master.sv - single-outstanding read/write master for a multiplexed address/data bus
// Bus strobes are decoded from state so an asynchronous reset releases the bus immediately.
module ad_read_write_master #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  ad_read_write_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, ADDR, TURN, RWAIT, WDATA, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic        write_q;
  logic [7:0]  wait_cnt;
  logic [15:0] rsp_data_q;
  logic        rsp_timeout_q;
  logic        last_wait;
  logic [15:0] ad_in_hi_unused;

  assign last_wait       = (wait_cnt == LAST_WAIT);
  assign ad_in_hi_unused = bus.ad_in[31:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (bus.req_valid) state_nxt = ADDR;
      ADDR:         state_nxt = write_q ? WDATA : TURN;
      TURN:         state_nxt = RWAIT;
      RWAIT, WDATA: if (bus.ack || last_wait) state_nxt = DONE;
      DONE:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Ack is checked before the timeout so an ack on the final wait cycle still succeeds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      wait_cnt      <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (bus.req_valid) begin
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            write_q       <= bus.req_write;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
          end
        end
        RWAIT, WDATA: begin
          if (bus.ack) begin
            rsp_data_q    <= (state == RWAIT) ? bus.ad_in[15:0] : 16'h0000;
            rsp_timeout_q <= 1'b0;
          end else if (last_wait) begin
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.ad_out      = '0;
    bus.ad_oe       = 1'b0;
    bus.ale         = 1'b0;
    bus.read_n      = 1'b1;
    bus.write_n     = 1'b1;
    bus.rsp_data    = rsp_data_q;
    bus.rsp_timeout = rsp_timeout_q;
    case (state)
      IDLE:  bus.req_ready = 1'b1;
      ADDR: begin
        bus.ad_out = addr_q;
        bus.ad_oe  = 1'b1;
        bus.ale    = 1'b1;
      end
      RWAIT: bus.read_n = 1'b0;
      WDATA: begin
        bus.ad_out  = {16'h0000, wdata_q};
        bus.ad_oe   = 1'b1;
        bus.write_n = 1'b0;
      end
      DONE:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ad_read_write_master.md
AD_READ_WRITE_MASTER -- requirements
Module: ad_read_write_master

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum data-phase cycles without ack before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  bus address.
REQ-008 req_wdata  input  16  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_data  output  16  read data; 0 for writes and timeouts.
REQ-011 rsp_timeout  output  1  qualifies rsp_valid; 1 = no ack within TIMEOUT.
REQ-012 ad_out  output  32  multiplexed address/data bus drive value.
REQ-013 ad_oe  output  1  1 = master drives ad; 0 = bus released.
REQ-014 ad_in  input  32  sampled bus value; read data on bits [15:0].
REQ-015 ale  output  1  address-latch strobe.
REQ-016 read_n  output  1  active-low read strobe; target drives ad while low.
REQ-017 write_n  output  1  active-low write strobe.
REQ-018 ack  input  1  target data-phase acknowledge, sampled on posedge clk.

Function
REQ-019 States SHALL be IDLE, ADDR, TURN, RWAIT, WDATA, DONE; all outputs SHALL be registered or decoded from state only.
REQ-020 IDLE: req_ready=1; req_valid=1 SHALL latch req_addr/req_write/req_wdata and go to ADDR.
REQ-021 ADDR (1 cycle): ad_out=latched addr, ad_oe=1, ale=1; then WDATA if write, else TURN.
REQ-022 TURN (1 cycle, reads only): ad_oe=0, ale=0, read_n=1; then RWAIT.
REQ-023 RWAIT: ad_oe=0, read_n=0; ack=1 SHALL capture ad_in[15:0] into rsp_data and go to DONE.
REQ-024 WDATA: ad_out={16'h0000, wdata}, ad_oe=1, write_n=0; ack=1 SHALL go to DONE.
REQ-025 An 8-bit wait counter SHALL clear on entry to RWAIT/WDATA and increment each cycle in them without ack.
REQ-026 If no ack in TIMEOUT consecutive data-phase cycles, SHALL go to DONE with rsp_timeout=1, rsp_data=0.
REQ-027 ack in the TIMEOUT-th cycle SHALL count as success (ack beats timeout).
REQ-028 DONE (1 cycle): rsp_valid=1 with rsp_data/rsp_timeout stable; all strobes inactive, ad_oe=0; then IDLE.
REQ-029 req_ready SHALL be 0 in every state except IDLE; req_valid outside IDLE is ignored and not queued.
REQ-030 ack outside RWAIT/WDATA SHALL be ignored.
REQ-031 ad_out SHALL be 0 whenever ad_oe=0.
REQ-032 read_n and write_n SHALL never be low simultaneously; ale SHALL never be high with a strobe low.
REQ-033 Read latency with ack on first RWAIT cycle: request accepted cycle 0, rsp_valid at cycle 4; write with first-cycle ack: rsp_valid at cycle 3.
REQ-034 Back-to-back: a request presented the cycle after DONE SHALL be accepted that cycle.

Reset
REQ-035 reset=1 SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_timeout=0, ad_out=0, ad_oe=0, ale=0, read_n=1, write_n=1, counter=0.
REQ-036 reset asserted mid-transaction SHALL abort it without rsp_valid; the bus SHALL be released asynchronously.
REQ-037 First request after reset deasserts SHALL be accepted on the first clk edge with req_valid=1.

Verification
REQ-038 Read addr 32'h0000_1234, ack on 1st RWAIT cycle with ad_in=32'hXXXX_BEEF -> ale pulse with ad_out=32'h0000_1234, rsp_valid at cycle 4, rsp_data=16'hBEEF, rsp_timeout=0.
REQ-039 Write addr 32'h10, wdata 16'hA5A5, ack after 3 cycles -> ad_out=32'h0000_A5A5 with write_n=0 for 4 cycles, rsp_valid, rsp_data=0.
REQ-040 Read, ack never asserted, TIMEOUT=15 -> read_n low exactly 15 cycles, rsp_valid with rsp_timeout=1, rsp_data=0.
REQ-041 Read with ack exactly on 15th RWAIT cycle -> success, rsp_timeout=0, captured data returned.
REQ-042 reset asserted during RWAIT -> same-cycle ad_oe=0, read_n=1, state IDLE, no rsp_valid.
REQ-043 Two requests back-to-back with req_valid held high and stray ack in IDLE/ADDR -> both complete in order, stray ack ignored, req_ready low except in IDLE.
